// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the LEGv8 instruction fetch stage.
// Holds word/instruction widths, the PC step, the fetch FSM encoding and a
// saturating increment helper used by the optional performance counters.
package ifetch_unit_pkg;

    localparam int WORD  = 64;
    localparam int INSTR = 32;

    localparam logic [WORD-1:0] PC_STEP = 64'd4;

    typedef enum logic [1:0] {
        F_IDLE    = 2'd0,
        F_WAIT    = 2'd1,
        F_DISCARD = 2'd2
    } fstate_e;

    function automatic logic [WORD-1:0] sat_inc(
        input logic [WORD-1:0] v
    );
        return (&v) ? v : v + WORD'(1);
    endfunction

endpackage

// File: rtl/ifetch_unit_fetch_queue.sv
// fetch_queue: synchronous FIFO of packed {pc, instr} entries, DEPTH deep.
// Ports: push/pop/flush controls, din/dout data, empty/full/count status.
// flush has priority over push and pop; dout is the head entry storage.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: LEGv8 fetch stage. Owns the fetch PC, issues single
// outstanding imem requests, queues responses in fetch_queue for decode and
// redirects/flushes on a taken branch from execute.
// Ports: clk/reset (sync, active-high); branch_target/zero/branch_in/
// uncond_branch_in from execute; stall from decode; imem_req/imem_addr out,
// imem_valid/imem_rdata in; instr_valid/pc_out/instruction_out to IF/ID.
// Optional: define IFETCH_PERF_CNT_EN to add fetch_count and flush_count.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter int              FIFO_DEPTH = 4,
    parameter logic [WORD-1:0] RESET_PC   = '0,
    parameter int              INSTR_W    = INSTR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WORD-1:0]    branch_target,
    input  logic               zero,
    input  logic               branch_in,
    input  logic               uncond_branch_in,
    input  logic               stall,
    output logic               imem_req,
    output logic [WORD-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [WORD-1:0]    pc_out,
    output logic [INSTR_W-1:0] instruction_out
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [WORD-1:0]    fetch_count,
    output logic [WORD-1:0]    flush_count
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int QW = WORD + INSTR_W;

    fstate_e         state_q, state_d;
    logic [WORD-1:0] fetch_pc_q, fetch_pc_d;
    logic [WORD-1:0] req_pc_q, req_pc_d;

    logic            redirect;
    logic            issue;
    logic            q_push, q_pop;
    logic            q_empty, q_full;
    logic [CW-1:0]   q_count;
    logic [QW-1:0]   q_dout;

    assign redirect = uncond_branch_in | (branch_in & zero);

    // Gating on occupancy at issue time guarantees a slot for the response.
    assign issue = (state_q == F_IDLE) && !redirect && !reset
                && (q_count < CW'(FIFO_DEPTH));

    // Responses are only accepted while a live request is pending.
    assign q_push = (state_q == F_WAIT) && imem_valid && !redirect
                 && (!q_full || q_pop);
    assign q_pop  = !q_empty && !stall && !redirect;

    fetch_queue #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (QW)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (q_push),
        .pop   (q_pop),
        .flush (redirect),
        .din   ({req_pc_q, imem_rdata}),
        .dout  (q_dout),
        .empty (q_empty),
        .full  (q_full),
        .count (q_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= F_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            F_IDLE: begin
                if (issue) state_d = F_WAIT;
            end
            F_WAIT: begin
                if (imem_valid)    state_d = F_IDLE;
                else if (redirect) state_d = F_DISCARD;
            end
            F_DISCARD: begin
                if (imem_valid) state_d = F_IDLE;
            end
            default: state_d = F_IDLE;
        endcase
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        if (redirect) begin
            fetch_pc_d = branch_target;
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
            req_pc_d   = fetch_pc_q;
        end
    end

    always_comb begin
        imem_req        = issue;
        imem_addr       = fetch_pc_q;
        instr_valid     = !q_empty;
        pc_out          = '0;
        instruction_out = '0;
        if (!q_empty) begin
            pc_out          = q_dout[QW-1:INSTR_W];
            instruction_out = q_dout[INSTR_W-1:0];
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [WORD-1:0] fetch_count_q, fetch_count_d;
    logic [WORD-1:0] flush_count_q, flush_count_d;
    logic            lost_work;

    // A redirect only counts as a flush when it throws real work away.
    assign lost_work = !q_empty || (state_q == F_WAIT);

    always_comb begin
        fetch_count_d = fetch_count_q;
        flush_count_d = flush_count_q;
        if (q_pop) begin
            fetch_count_d = sat_inc(fetch_count_q);
        end
        if (redirect && lost_work) begin
            flush_count_d = sat_inc(flush_count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: queue-based fetch model, imem
// responder with variable latency, directed scenarios plus random traffic.
module tb_ifetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] branch_target = '0;
    logic        zero = 1'b0;
    logic        branch_in = 1'b0;
    logic        uncond_branch_in = 1'b0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [63:0] pc_out;
    logic [31:0] instruction_out;

    ifetch_unit #(
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (64'h0),
        .INSTR_W    (32)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .branch_target    (branch_target),
        .zero             (zero),
        .branch_in        (branch_in),
        .uncond_branch_in (uncond_branch_in),
        .stall            (stall),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_valid       (imem_valid),
        .imem_rdata       (imem_rdata),
        .instr_valid      (instr_valid),
        .pc_out           (pc_out),
        .instruction_out  (instruction_out)
    );

    always #5 clk = ~clk;

    // reference model: fetch pc, one outstanding request, queue of pcs
    logic [63:0] m_pc = 64'h0;
    logic [63:0] m_pend_pc = '0;
    bit          m_pend = 0;
    bit          m_disc = 0;
    logic [63:0] m_q [$];

    // imem environment
    bit          env_out = 0;
    bit          ghost = 0;
    logic [63:0] env_addr = '0;
    logic [63:0] ghost_addr = '0;
    int          env_wait = 0;
    int          dly = 0;

    // observations from the last cycle
    logic        o_req, o_iv;
    logic [63:0] o_addr, o_pc;
    logic [31:0] o_ins;
    logic [63:0] popped [$];

    int n_pass = 0;
    int n_tot = 0;

    function automatic logic [31:0] insn(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic cyc(input logic r, input logic b, input logic z,
                       input logic u, input logic [63:0] t,
                       input logic s);
        logic redir, exp_req, pop_now;
        logic [63:0] hd;
        @(negedge clk);
        reset = r; branch_in = b; zero = z;
        uncond_branch_in = u; branch_target = t; stall = s;
        if (r && env_out) begin
            ghost = 1; ghost_addr = env_addr; env_out = 0;
        end
        imem_valid = 1'b0;
        imem_rdata = '0;
        if (!r && ghost) begin
            imem_valid = 1'b1; imem_rdata = insn(ghost_addr); ghost = 0;
        end else if (env_out) begin
            if (env_wait == 0) begin
                imem_valid = 1'b1; imem_rdata = insn(env_addr);
                env_out = 0;
            end else begin
                env_wait--;
            end
        end
        #1;
        redir = u | (b & z);
        exp_req = !r && !m_pend && !m_disc && !redir
               && (m_q.size() < DEPTH);
        hd = (m_q.size() != 0) ? m_q[0] : 64'h0;
        chk("imem_req", imem_req, exp_req);
        if (exp_req && imem_req) chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", instr_valid, m_q.size() != 0);
        chk("pc_out", pc_out, hd);
        chk("instruction_out", instruction_out,
            (m_q.size() != 0) ? 64'(insn(hd)) : 64'h0);
        o_req = imem_req; o_addr = imem_addr; o_iv = instr_valid;
        o_pc = pc_out; o_ins = instruction_out;
        if (instr_valid && !s && !redir && !r) popped.push_back(pc_out);
        if (imem_req) begin
            if (env_out) chk("imem_overlap", 1, 0);
            env_out = 1; env_addr = imem_addr;
            env_wait = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
        end
        if (r) begin
            m_q.delete(); m_pend = 0; m_disc = 0; m_pc = 64'h0;
        end else if (redir) begin
            m_q.delete();
            if (m_pend && !imem_valid) m_disc = 1;
            else if (m_disc && imem_valid) m_disc = 0;
            m_pend = 0;
            m_pc = t;
        end else begin
            pop_now = (m_q.size() != 0) && !s;
            if (pop_now) void'(m_q.pop_front());
            if (m_pend && imem_valid) begin
                m_q.push_back(m_pend_pc); m_pend = 0;
            end
            if (m_disc && imem_valid) m_disc = 0;
            if (exp_req) begin
                m_pend = 1; m_pend_pc = m_pc; m_pc = m_pc + 64'd4;
            end
        end
    endtask

    task automatic idle(input int n, input logic s);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 64'h0, s);
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 64'h0, 0);
        cyc(1, 0, 0, 0, 64'h0, 0);
        popped.delete();
    endtask

    initial begin
        bit got;
        logic [63:0] fa;
        int k;

        // reset state
        dly = 0;
        do_reset();
        chk("rst_iv", o_iv, 0);
        chk("rst_pc", o_pc, 64'h0);
        chk("rst_ins", 64'(o_ins), 64'h0);

        // 1: streaming, 1-cycle imem latency
        cyc(0, 0, 0, 0, 64'h0, 0);
        chk("t1_req0", o_req, 1);
        chk("t1_addr0", o_addr, 64'h0);
        cyc(0, 0, 0, 0, 64'h0, 0);
        cyc(0, 0, 0, 0, 64'h0, 0);
        chk("t1_iv3", o_iv, 1);
        chk("t1_pc3", o_pc, 64'h0);
        chk("t1_ins3", 64'(o_ins), 64'h5A5A_C3C3);
        k = 0;
        while (popped.size() < 4 && k < 40) begin
            idle(1, 0); k++;
        end
        chk("t1_npop", popped.size() >= 4, 1);
        if (popped.size() >= 4) begin
            chk("t1_p0", popped[0], 64'h0);
            chk("t1_p1", popped[1], 64'h4);
            chk("t1_p2", popped[2], 64'h8);
            chk("t1_p3", popped[3], 64'hC);
        end

        // 2: stall fills the queue, release drains in order
        do_reset();
        idle(12, 1);
        chk("t2_noreq", o_req, 0);
        chk("t2_iv", o_iv, 1);
        chk("t2_head", o_pc, 64'h0);
        got = 0; fa = '0;
        for (int i = 0; i < 6; i++) begin
            idle(1, 0);
            if (o_req && !got) begin got = 1; fa = o_addr; end
        end
        chk("t2_npop", popped.size() >= 4, 1);
        if (popped.size() >= 4) begin
            chk("t2_p0", popped[0], 64'h0);
            chk("t2_p1", popped[1], 64'h4);
            chk("t2_p2", popped[2], 64'h8);
            chk("t2_p3", popped[3], 64'hC);
        end
        chk("t2_resume", fa, 64'h10);

        // 3: taken CBZ with entries queued
        do_reset();
        idle(4, 1);
        chk("t3_iv_pre", o_iv, 1);
        cyc(0, 1, 1, 0, 64'h100, 1);
        cyc(0, 0, 0, 0, 64'h0, 0);
        chk("t3_iv_off", o_iv, 0);
        chk("t3_req", o_req, 1);
        chk("t3_addr", o_addr, 64'h100);
        cyc(0, 0, 0, 0, 64'h0, 0);
        cyc(0, 0, 0, 0, 64'h0, 0);
        chk("t3_iv_on", o_iv, 1);
        chk("t3_pc", o_pc, 64'h100);

        // 4: not-taken CBZ, then unconditional B
        do_reset();
        for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, 64'h300, 0);
        chk("t4_npop", popped.size() >= 5, 1);
        foreach (popped[i]) chk("t4_seq", popped[i], 64'(4 * i));
        cyc(0, 0, 0, 1, 64'h300, 0);
        cyc(0, 0, 0, 0, 64'h0, 0);
        chk("t4_b_req", o_req, 1);
        chk("t4_b_addr", o_addr, 64'h300);

        // 5: redirect while a request is in flight
        do_reset();
        dly = 2;
        k = 0; got = 0;
        while (!got && k < 100) begin
            idle(1, 0); k++;
            if (o_req && o_addr == 64'h20) got = 1;
        end
        chk("t5_saw_req", got, 1);
        cyc(0, 1, 1, 0, 64'h200, 0);
        popped.delete();
        idle(30, 0);
        chk("t5_npop", popped.size() > 0, 1);
        if (popped.size() > 0) chk("t5_first", popped[0], 64'h200);

        // 6: reset with a request outstanding
        dly = 0;
        do_reset();
        idle(5, 1);
        chk("t6_out", o_req, 1);
        cyc(1, 0, 0, 0, 64'h0, 0);
        cyc(0, 0, 0, 0, 64'h0, 0);
        chk("t6_iv", o_iv, 0);
        chk("t6_pc", o_pc, 64'h0);
        chk("t6_req", o_req, 1);
        chk("t6_addr", o_addr, 64'h0);
        cyc(0, 0, 0, 0, 64'h0, 0);
        cyc(0, 0, 0, 0, 64'h0, 0);
        chk("t6_pc_new", o_pc, 64'h0);
        chk("t6_iv_new", o_iv, 1);

        // random traffic
        dly = -1;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            logic r, b, z, u, s;
            logic [63:0] t;
            int sel;
            sel = $urandom_range(0, 19);
            r = ($urandom_range(0, 299) == 0);
            b = (sel < 2);
            u = (sel == 2);
            z = 1'($urandom);
            s = ($urandom_range(0, 9) < 3);
            t = {$urandom, $urandom} & ~64'h3;
            if ($urandom_range(0, 3) == 0) t = 64'hFFFF_FFFF_FFFF_FFF4;
            cyc(r, b, z, u, t, s);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
